// File: rtl/crc24_gen_pkg.sv
// -----------------------------------------------------------------------------
// crc24_gen_pkg
// Shared CRC-24 constants and FSM state codes. Used by the CRC generator, the
// whitening stage and the receive-side CRC checker.
// -----------------------------------------------------------------------------
package crc24_gen_pkg;

    localparam int unsigned CRC_LEN = 24;
    localparam int unsigned CNT_W   = 5;

    localparam logic [CRC_LEN-1:0] POLY             = 24'h00065B;
    localparam logic [CRC_LEN-1:0] CRC_INIT_DEFAULT = 24'h555555;

    // Generator FSM state codes; all four 2-bit codes are assigned
    typedef logic [1:0] crc_state_t;
    localparam crc_state_t StIdle = 2'd0;
    localparam crc_state_t StData = 2'd1;
    localparam crc_state_t StWait = 2'd2;
    localparam crc_state_t StSend = 2'd3;

endpackage

// File: rtl/crc24_gen_if.sv
// -----------------------------------------------------------------------------
// crc24_gen_if
// Serial payload / CRC stream bundle between the packet FIFO, the CRC
// generator and the whitening stage.
//   data_in, data_in_valid     : serial payload from packet FIFO
//   data_out, data_out_valid   : payload forwarded to whitening stage
//   crc_out, crc_out_valid     : serial CRC (MSB first) to whitening stage
//   busy, ovr_err              : status
// slave  : the CRC generator side
// master : the upstream driver / observer side
// -----------------------------------------------------------------------------
interface crc24_gen_if;

    logic data_in;
    logic data_in_valid;
    logic data_out;
    logic data_out_valid;
    logic crc_out;
    logic crc_out_valid;
    logic busy;
    logic ovr_err;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_out,
        input  data_out_valid,
        input  crc_out,
        input  crc_out_valid,
        input  busy,
        input  ovr_err
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_out,
        output data_out_valid,
        output crc_out,
        output crc_out_valid,
        output busy,
        output ovr_err
    );

endinterface

// File: rtl/crc24_lfsr.sv
// -----------------------------------------------------------------------------
// crc24_lfsr
// Combinational single-bit CRC-24 step (Galois form, MSB-aligned feedback).
//   i_lfsr      : current remainder
//   i_bit       : message bit being absorbed
//   o_lfsr_next : remainder after absorbing i_bit
// -----------------------------------------------------------------------------
module crc24_lfsr
    import crc24_gen_pkg::*;
(
    input  logic [CRC_LEN-1:0] i_lfsr,
    input  logic               i_bit,
    output logic [CRC_LEN-1:0] o_lfsr_next
);

    logic w_fb;

    always_comb begin
        w_fb        = i_lfsr[CRC_LEN-1] ^ i_bit;
        o_lfsr_next = {i_lfsr[CRC_LEN-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end

endmodule

// File: rtl/crc24_gen.sv
// -----------------------------------------------------------------------------
// crc24_gen
// Serial CRC-24 generator. Payload bits pass straight through to the whitening
// stage while being absorbed into the LFSR; after the burst ends, one idle
// (WAIT) cycle separates payload from the 24 CRC bits shifted out MSB first.
//   clk    : clock, state advances on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : crc24_gen_if.slave (payload in, payload/CRC out, busy, ovr_err)
// -----------------------------------------------------------------------------
module crc24_gen
    import crc24_gen_pkg::*;
#(
    parameter logic [CRC_LEN-1:0] CRC_INIT = CRC_INIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    crc24_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_LEN - 1);

    crc_state_t         r_state;
    crc_state_t         w_state_nxt;
    logic [CRC_LEN-1:0] r_lfsr;
    logic [CRC_LEN-1:0] w_lfsr_nxt;
    logic [CRC_LEN-1:0] w_lfsr_step;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_ovr;
    logic               w_ovr_nxt;
    logic               w_accepting;

    crc24_lfsr u_lfsr (
        .i_lfsr      (r_lfsr),
        .i_bit       (bus.data_in),
        .o_lfsr_next (w_lfsr_step)
    );

    assign w_accepting = (r_state == StIdle) || (r_state == StData);

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle: begin
                // lfsr already holds CRC_INIT here, so the first bit steps from it
                if (bus.data_in_valid) begin
                    w_lfsr_nxt  = w_lfsr_step;
                    w_state_nxt = StData;
                end
            end
            StData: begin
                if (bus.data_in_valid) begin
                    w_lfsr_nxt = w_lfsr_step;
                end else begin
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                w_state_nxt = StSend;
                w_cnt_nxt   = '0;
            end
            StSend: begin
                w_lfsr_nxt = {r_lfsr[CRC_LEN-2:0], 1'b0};
                w_cnt_nxt  = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = StIdle;
                    w_lfsr_nxt  = CRC_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_lfsr_nxt  = CRC_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Valid input while the CRC window is open is dropped and flagged
    assign w_ovr_nxt = bus.data_in_valid && !w_accepting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_lfsr  <= CRC_INIT;
            r_cnt   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    // Payload path is zero-latency; gated by rst_n so nothing leaks during reset
    assign bus.data_out       = bus.data_in;
    assign bus.data_out_valid = rst_n && bus.data_in_valid && w_accepting;

    assign bus.crc_out_valid  = (r_state == StSend);
    assign bus.crc_out        = (r_state == StSend) && r_lfsr[CRC_LEN-1];
    assign bus.busy           = (r_state != StIdle);
    assign bus.ovr_err        = r_ovr;

endmodule

// File: tb/tb_crc24_gen.sv
// -----------------------------------------------------------------------------
// tb_crc24_gen
// Two generators (default init and all-zero init) share one stimulus stream.
// A schedule-based reference (packet bit queue, CRC window start/end cycle)
// predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_crc24_gen;
    import crc24_gen_pkg::*;

    localparam logic [23:0] INIT_Z = 24'h000000;

    logic clk = 1'b0;
    logic rst_n;
    logic drv_v;
    logic drv_b;

    int n_pass  = 0;
    int n_total = 0;

    crc24_gen_if if_d ();
    crc24_gen_if if_z ();

    assign if_d.data_in       = drv_b;
    assign if_d.data_in_valid = drv_v;
    assign if_z.data_in       = drv_b;
    assign if_z.data_in_valid = drv_v;

    crc24_gen #(.CRC_INIT(CRC_INIT_DEFAULT)) dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_d.slave)
    );

    crc24_gen #(.CRC_INIT(INIT_Z)) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_z.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Remainder of the message over POLY, starting from init (bit-serial division)
    function automatic logic [23:0] crc_of(input logic [23:0] init, input bit bits[$]);
        logic [23:0] r;
        r = init;
        foreach (bits[i]) begin
            if (r[23] ^ bits[i]) r = (r << 1) ^ POLY;
            else                 r = r << 1;
        end
        return r;
    endfunction

    // ---------------- reference schedule + per-cycle compare ----------------
    int          cyc       = 0;
    bit          in_pkt    = 0;
    bit          pkt[$];
    int          win_start = -100;
    int          win_end   = -100;
    bit          ovr_pend  = 0;
    logic [23:0] crc_d_exp = '0;
    logic [23:0] crc_z_exp = '0;
    logic [23:0] rx_d      = '0;
    logic [23:0] rx_z      = '0;

    always @(negedge clk) begin
        bit   in_win;
        bit   sending;
        int   k;
        logic exp_co_d;
        logic exp_co_z;
        cyc++;
        if (!rst_n) begin
            check("rst_dov_d",  {31'd0, if_d.data_out_valid}, 32'd0);
            check("rst_cv_d",   {31'd0, if_d.crc_out_valid},  32'd0);
            check("rst_co_d",   {31'd0, if_d.crc_out},        32'd0);
            check("rst_busy_d", {31'd0, if_d.busy},           32'd0);
            check("rst_ovr_d",  {31'd0, if_d.ovr_err},        32'd0);
            check("rst_cv_z",   {31'd0, if_z.crc_out_valid},  32'd0);
            check("rst_busy_z", {31'd0, if_z.busy},           32'd0);
            in_pkt    = 0;
            pkt.delete();
            win_start = -100;
            win_end   = -100;
            ovr_pend  = 0;
        end else begin
            // window = one WAIT cycle followed by 24 SEND cycles
            in_win   = (cyc >= win_start - 1) && (cyc <= win_end);
            sending  = (cyc >= win_start) && (cyc <= win_end);
            k        = cyc - win_start;
            exp_co_d = sending ? crc_d_exp[23 - k] : 1'b0;
            exp_co_z = sending ? crc_z_exp[23 - k] : 1'b0;

            check("data_out_d", {31'd0, if_d.data_out},       {31'd0, drv_b});
            check("dov_d",      {31'd0, if_d.data_out_valid}, {31'd0, drv_v && !in_win});
            check("cv_d",       {31'd0, if_d.crc_out_valid},  {31'd0, sending});
            check("co_d",       {31'd0, if_d.crc_out},        {31'd0, exp_co_d});
            check("busy_d",     {31'd0, if_d.busy},           {31'd0, in_pkt || in_win});
            check("ovr_d",      {31'd0, if_d.ovr_err},        {31'd0, ovr_pend});
            check("dov_z",      {31'd0, if_z.data_out_valid}, {31'd0, drv_v && !in_win});
            check("cv_z",       {31'd0, if_z.crc_out_valid},  {31'd0, sending});
            check("co_z",       {31'd0, if_z.crc_out},        {31'd0, exp_co_z});
            check("busy_z",     {31'd0, if_z.busy},           {31'd0, in_pkt || in_win});
            check("ovr_z",      {31'd0, if_z.ovr_err},        {31'd0, ovr_pend});

            if (if_d.crc_out_valid) rx_d = {rx_d[22:0], if_d.crc_out};
            if (if_z.crc_out_valid) rx_z = {rx_z[22:0], if_z.crc_out};

            ovr_pend = drv_v && in_win;
            if (!in_win) begin
                if (drv_v) begin
                    pkt.push_back(drv_b);
                    in_pkt = 1;
                end else if (in_pkt) begin
                    crc_d_exp = crc_of(CRC_INIT_DEFAULT, pkt);
                    crc_z_exp = crc_of(INIT_Z, pkt);
                    win_start = cyc + 2;
                    win_end   = cyc + 25;
                    in_pkt    = 0;
                    pkt.delete();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit b, input bit r);
        drv_v = v;
        drv_b = b;
        rst_n = r;
        @(posedge clk);
        #1;
    endtask

    // Payload burst, then the 26 cycles up to and including the last SEND
    // cycle (j=0 first invalid, j=1 WAIT, j=2..25 SEND). Optional stray valid
    // or reset inside that span.
    task automatic send_pkt(input bit bits[$], input int stray_at, input int rst_at);
        foreach (bits[i]) drive(1'b1, bits[i], 1'b1);
        for (int j = 0; j < 26; j++) begin
            if (j == rst_at) drive(1'b0, 1'b0, 1'b0);
            else             drive(j == stray_at, 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        bit q[$];
        drv_v = 1'b0;
        drv_b = 1'b0;
        rst_n = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // hand-computed pins on the reference itself
        q = '{1'b1};
        check("model_z_bit1", crc_of(INIT_Z, q), 24'h00065B);
        q = '{1'b0, 1'b0};
        check("model_d_bits00", crc_of(CRC_INIT_DEFAULT, q), 24'h55530F);

        // first packet right after reset release
        q = '{1'b1};
        send_pkt(q, -1, -1);
        check("crc_z_bit1", {8'd0, rx_z}, 32'h00065B);
        check("crc_d_bit1", {8'd0, rx_d}, 32'hAAACF1);

        // back-to-back: each starts in the single IDLE cycle after the window
        q = '{1'b0};
        send_pkt(q, -1, -1);
        check("crc_d_bit0", {8'd0, rx_d}, 32'hAAAAAA);
        check("crc_z_bit0", {8'd0, rx_z}, 32'h000000);
        q = '{1'b0, 1'b0};
        send_pkt(q, -1, -1);
        check("crc_d_bits00", {8'd0, rx_d}, 32'h55530F);

        // stray valid in SEND cycle 10, then in the last SEND cycle
        q = '{1'b1, 1'b0, 1'b1, 1'b1};
        send_pkt(q, 12, -1);
        check("crc_d_stray", {8'd0, rx_d}, {8'd0, crc_of(CRC_INIT_DEFAULT, q)});
        send_pkt(q, 25, -1);
        check("crc_z_stray_last", {8'd0, rx_z}, {8'd0, crc_of(INIT_Z, q)});

        // reset during SEND cycle 12, then a clean packet
        send_pkt(q, -1, 14);
        q = '{1'b0, 1'b0};
        send_pkt(q, -1, -1);
        check("crc_d_after_rst", {8'd0, rx_d}, 32'h55530F);

        // zero-length: idle cycles only
        repeat (5) drive(1'b0, 1'b0, 1'b1);

        // randomized packets, strays, aborts and idle gaps
        for (int p = 0; p < 60; p++) begin
            int len;
            int stray;
            int rst_at;
            len = $urandom_range(1, 40);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(1'($urandom_range(0, 1)));
            stray  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : -1;
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 25)) : -1;
            send_pkt(q, stray, rst_at);
            repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
